// File: rtl/spi_ctrl_pkg.sv
// Shared encodings and defaults for the SPI word sequencer.
// Holds the FSM state type, default frame width/idle word and the bit-counter width helper.
package spi_ctrl_pkg;

    localparam int          DEF_DATA_W    = 32;
    localparam logic [31:0] DEF_IDLE_WORD = 32'h0000_0000;

    // Counter must be able to hold DATA_W itself, hence the extra bit.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_DONE    = 2'd2,
        ST_WAIT_HI = 2'd3
    } state_t;

endpackage

// File: rtl/spi_word_sreg.sv
// Paired TX/RX shift registers: parallel load of TX, MSB-first shift out, serial shift in of RX.
// Latency: load/shift take effect on the next edge; no backpressure, steps only when told to.
module spi_word_sreg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_word,
    input  logic              shift,
    input  logic              mosi_bit,
    output logic              tx_msb,
    output logic [DATA_W-1:0] rx_word
);

    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_sr <= '0;
            rx_sr <= '0;
        end else if (load) begin
            tx_sr <= load_word;
            rx_sr <= '0;
        end else if (shift) begin
            tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            rx_sr <= {rx_sr[DATA_W-2:0], mosi_bit};
        end
    end

    assign tx_msb  = tx_sr[DATA_W-1];
    assign rx_word = rx_sr;

endmodule

// File: rtl/spi_word_ctrl.sv
// Frames spi_slave bit shifts into words; rx_valid rises 2 cycles after transaction_done.
// One-entry TX/RX buffers, full RX drops new word (overrun); sticky flags only with SPI_WORD_CTRL_ERR_EN.
module spi_word_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [DATA_W-1:0] IDLE_WORD = DEF_IDLE_WORD
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ss,
    input  logic              shift_en,
    input  logic              transaction_done,
    input  logic              mosi_bit,
    output logic              miso_bit,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              overrun,
    output logic              underrun,
    output logic              frame_err,
    input  logic              clr_err
);

    localparam int             CW       = cnt_width(DATA_W);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DATA_W);

    state_t            state, state_nxt;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] tx_buf;
    logic              tx_full;
    logic [DATA_W-1:0] rx_word;

    logic frame_start, do_shift, abort, done_chk;
    logic cnt_ok, rx_load, ovr_evt, ferr_evt, urun_evt;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        do_shift    = 1'b0;
        abort       = 1'b0;
        done_chk    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!ss) begin
                    frame_start = 1'b1;
                    state_nxt   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A shift coincident with done still counts before the length check.
                do_shift = shift_en;
                if (transaction_done) begin
                    state_nxt = ST_DONE;
                end else if (ss) begin
                    abort     = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DONE: begin
                done_chk  = 1'b1;
                state_nxt = ss ? ST_IDLE : ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (ss) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign cnt_ok   = (bit_cnt == FULL_CNT);
    assign rx_load  = done_chk && cnt_ok && (!rx_valid || rx_ready);
    assign ovr_evt  = done_chk && cnt_ok && rx_valid && !rx_ready;
    assign ferr_evt = abort || (done_chk && !cnt_ok);
    assign urun_evt = frame_start && !tx_full;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tx_buf   <= '0;
            tx_full  <= 1'b0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            // A word accepted on the frame-start edge waits for the next frame.
            if (frame_start && tx_full) begin
                tx_full <= 1'b0;
            end else if (tx_valid && !tx_full) begin
                tx_full <= 1'b1;
                tx_buf  <= tx_data;
            end

            if (frame_start)             bit_cnt <= '0;
            else if (do_shift && !cnt_ok) bit_cnt <= bit_cnt + CW'(1);

            if (rx_load) begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
            end else if (rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    spi_word_sreg #(.DATA_W(DATA_W)) u_sreg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (frame_start),
        .load_word (tx_full ? tx_buf : IDLE_WORD),
        .shift     (do_shift),
        .mosi_bit  (mosi_bit),
        .tx_msb    (miso_bit),
        .rx_word   (rx_word)
    );

    assign tx_ready = !tx_full;
    assign busy     = (state != ST_IDLE);

`ifdef SPI_WORD_CTRL_ERR_EN
    logic ovr_q, urun_q, ferr_q;

    // New events take priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovr_q  <= 1'b0;
            urun_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            ovr_q  <= ovr_evt  || (ovr_q  && !clr_err);
            urun_q <= urun_evt || (urun_q && !clr_err);
            ferr_q <= ferr_evt || (ferr_q && !clr_err);
        end
    end

    assign overrun   = ovr_q;
    assign underrun  = urun_q;
    assign frame_err = ferr_q;
`else
    logic unused_err;
    assign unused_err = ^{clr_err, ovr_evt, urun_evt, ferr_evt};

    assign overrun   = 1'b0;
    assign underrun  = 1'b0;
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_word_ctrl.sv
// Self-checking bench for spi_word_ctrl: table of full frames plus hand-written corner sequences.
module tb_spi_word_ctrl;

`ifdef SPI_WORD_CTRL_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        ss;
    logic        shift_en;
    logic        transaction_done;
    logic        mosi_bit;
    logic        miso_bit;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        busy;
    logic        overrun;
    logic        underrun;
    logic        frame_err;
    logic        clr_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] miso_q[$];
    logic [31:0] rx_q[$];

    spi_word_ctrl dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .ss               (ss),
        .shift_en         (shift_en),
        .transaction_done (transaction_done),
        .mosi_bit         (mosi_bit),
        .miso_bit         (miso_bit),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .busy             (busy),
        .overrun          (overrun),
        .underrun         (underrun),
        .frame_err        (frame_err),
        .clr_err          (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] tx;
        bit          use_tx;
        logic [31:0] mosi;
        logic [31:0] exp_miso;
        bit          exp_urun;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_errs();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    task automatic offer_tx(input logic [31:0] w);
        tx_data  = w;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        chk("tx_ready_after_accept", tx_ready, 1'b0);
    endtask

    // Drives one frame; the last step is the DONE (or abort) edge with ss per 'hold'.
    task automatic frame(input logic [31:0] mosi, input int nsh, input bit with_done,
                         input bit rdy_done, input bit hold, output logic pre_vld);
        logic [31:0] got;
        got = '0;
        ss = 1'b0;
        step();
        tx_valid = 1'b0;
        chk("busy_at_start", busy, 1'b1);
        for (int i = 0; i < nsh; i++) begin
            got              = {got[30:0], miso_bit};
            shift_en         = 1'b1;
            mosi_bit         = mosi[31-i];
            transaction_done = with_done && (i == nsh - 1);
            step();
            shift_en         = 1'b0;
            transaction_done = 1'b0;
            mosi_bit         = 1'b0;
        end
        if (nsh == 32) begin
            if (miso_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL miso_sb: got %h expected nothing queued", got);
            end else begin
                chk("miso_word", got, miso_q.pop_front());
            end
        end
        pre_vld  = rx_valid;
        rx_ready = rdy_done;
        ss       = !hold;
        step();
        rx_ready = 1'b0;
    endtask

    task automatic consume();
        chk("rx_valid_before_pop", rx_valid, 1'b1);
        if (rx_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rx_sb: got %h expected nothing queued", rx_data);
        end else if (rx_valid) begin
            chk("rx_data", rx_data, rx_q.pop_front());
            rx_ready = 1'b1;
            step();
            rx_ready = 1'b0;
            chk("rx_valid_after_pop", rx_valid, 1'b0);
        end
    endtask

    initial begin
        vec_t vecs[4];
        logic pv;

        vecs[0] = '{tx: 32'hA5A5_0F0F, use_tx: 1'b1, mosi: 32'h1234_5678, exp_miso: 32'hA5A5_0F0F, exp_urun: 1'b0};
        vecs[1] = '{tx: 32'h0,         use_tx: 1'b0, mosi: 32'hDEAD_BEEF, exp_miso: 32'h0000_0000, exp_urun: 1'b1};
        vecs[2] = '{tx: 32'hFFFF_0000, use_tx: 1'b1, mosi: 32'h0000_FFFF, exp_miso: 32'hFFFF_0000, exp_urun: 1'b0};
        vecs[3] = '{tx: 32'h8000_0001, use_tx: 1'b1, mosi: 32'h7FFF_FFFE, exp_miso: 32'h8000_0001, exp_urun: 1'b0};

        reset_n = 1'b0; ss = 1'b1; shift_en = 1'b0; transaction_done = 1'b0;
        mosi_bit = 1'b0; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; clr_err = 1'b0;
        step();
        step();
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_data", rx_data, 32'h0);
        chk("rst_miso", miso_bit, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_flags", {overrun, underrun, frame_err}, 3'b000);
        reset_n = 1'b1;
        step();

        // Table of complete frames, each consumed before the next.
        for (int k = 0; k < 4; k++) begin
            clear_errs();
            if (vecs[k].use_tx) offer_tx(vecs[k].tx);
            miso_q.push_back(vecs[k].exp_miso);
            rx_q.push_back(vecs[k].mosi);
            frame(vecs[k].mosi, 32, 1'b1, 1'b0, 1'b0, pv);
            chk("rx_valid_latency_pre", pv, 1'b0);
            chk("rx_valid_latency", rx_valid, 1'b1);
            chk("busy_after_frame", busy, 1'b0);
            chk("tx_ready_after_frame", tx_ready, 1'b1);
            chk("underrun_tbl", underrun, ERR & vecs[k].exp_urun);
            chk("overrun_tbl", overrun, 1'b0);
            chk("frame_err_tbl", frame_err, 1'b0);
            consume();
            if (vecs[k].exp_urun) begin
                clear_errs();
                chk("underrun_cleared", underrun, 1'b0);
            end
        end

        // Overrun: second word dropped, first kept.
        clear_errs();
        miso_q.push_back(32'h0); rx_q.push_back(32'h1111_1111);
        frame(32'h1111_1111, 32, 1'b1, 1'b0, 1'b0, pv);
        miso_q.push_back(32'h0);
        frame(32'h2222_2222, 32, 1'b1, 1'b0, 1'b0, pv);
        chk("ovr_rx_data", rx_data, 32'h1111_1111);
        chk("ovr_flag", overrun, ERR);
        consume();

        // Simultaneous consume and load in the DONE cycle.
        clear_errs();
        miso_q.push_back(32'h0); rx_q.push_back(32'h1111_1111);
        frame(32'h1111_1111, 32, 1'b1, 1'b0, 1'b0, pv);
        chk("sim_first", rx_data, rx_q.pop_front());
        miso_q.push_back(32'h0); rx_q.push_back(32'h2222_2222);
        frame(32'h2222_2222, 32, 1'b1, 1'b1, 1'b0, pv);
        chk("sim_rx_valid", rx_valid, 1'b1);
        chk("sim_overrun", overrun, 1'b0);
        consume();

        // Abort after 10 shifts leaves a pending word untouched.
        clear_errs();
        miso_q.push_back(32'h0); rx_q.push_back(32'h3333_3333);
        frame(32'h3333_3333, 32, 1'b1, 1'b0, 1'b0, pv);
        clear_errs();
        frame(32'hFFFF_FFFF, 10, 1'b0, 1'b0, 1'b0, pv);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rx_valid", rx_valid, 1'b1);
        chk("abort_frame_err", frame_err, ERR);
        consume();
        clear_errs();
        offer_tx(32'h0F0F_F0F0);
        miso_q.push_back(32'h0F0F_F0F0); rx_q.push_back(32'h55AA_55AA);
        frame(32'h55AA_55AA, 32, 1'b1, 1'b0, 1'b0, pv);
        chk("post_abort_ferr", frame_err, 1'b0);
        consume();

        // Short frame: done after 5 shifts is dropped.
        clear_errs();
        frame(32'hFFFF_FFFF, 5, 1'b1, 1'b0, 1'b0, pv);
        chk("short_rx_valid", rx_valid, 1'b0);
        chk("short_frame_err", frame_err, ERR);

        // TX offered on the frame-start edge underruns, then ss held low into WAIT_HI.
        clear_errs();
        tx_data = 32'hC3C3_3C3C; tx_valid = 1'b1;
        miso_q.push_back(32'h0); rx_q.push_back(32'h0F1E_2D3C);
        frame(32'h0F1E_2D3C, 32, 1'b1, 1'b0, 1'b1, pv);
        chk("same_cycle_tx_kept", tx_ready, 1'b0);
        chk("same_cycle_underrun", underrun, ERR);
        chk("wait_hi_busy", busy, 1'b1);
        shift_en = 1'b1; mosi_bit = 1'b1;
        for (int i = 0; i < 3; i++) step();
        shift_en = 1'b0; mosi_bit = 1'b0;
        chk("wait_hi_hold", busy, 1'b1);
        ss = 1'b1;
        step();
        chk("wait_hi_exit", busy, 1'b0);
        consume();
        miso_q.push_back(32'hC3C3_3C3C); rx_q.push_back(32'h2468_ACE0);
        frame(32'h2468_ACE0, 32, 1'b1, 1'b0, 1'b0, pv);
        consume();

        // Reset in the middle of SHIFT with a word buffered.
        offer_tx(32'hAAAA_5555);
        ss = 1'b0;
        step();
        tx_data = 32'h9999_6666; tx_valid = 1'b1; shift_en = 1'b1; mosi_bit = 1'b1;
        step();
        tx_valid = 1'b0;
        step();
        shift_en = 1'b0; mosi_bit = 1'b0;
        chk("mid_tx_full", tx_ready, 1'b0);
        chk("mid_busy", busy, 1'b1);
        reset_n = 1'b0;
        step();
        chk("mrst_tx_ready", tx_ready, 1'b1);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_miso", miso_bit, 1'b0);
        chk("mrst_rx", {rx_valid, rx_data}, 33'h0);
        chk("mrst_flags", {overrun, underrun, frame_err}, 3'b000);
        reset_n = 1'b1; ss = 1'b1;
        step();
        miso_q.push_back(32'h0); rx_q.push_back(32'h1357_9BDF);
        frame(32'h1357_9BDF, 32, 1'b1, 1'b0, 1'b0, pv);
        chk("post_rst_underrun", underrun, ERR);
        consume();

        chk("miso_sb_empty", miso_q.size(), 0);
        chk("rx_sb_empty", rx_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
